// File: rtl/cabac_ctx_init_engine.sv
// cabac_ctx_init_engine
//
// Initialises the CABAC context-state RAM at slice start. On an accepted
// start it walks CTX_NUM entries of one bank of an external synchronous
// init-value ROM, converts each packed {m, n} word into the HEVC initial
// state for the latched slice QP, and writes {pStateIdx, valMps} into the
// context RAM at one context per cycle.
//
// Optional feature (macro CABAC_INIT_FLAG_EN): adds cabac_init_flag_i.
// When the flag is set, banks 0 and 1 are swapped. Bank 2 is never swapped.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start_i            one-cycle init request (ignored unless idle)
//   slice_type_i       bank select, latched on accepted start
//   qp_i               slice QP, latched (clamped to 51) on accepted start
//   busy_o             high from the cycle after start through the done cycle
//   done_o             one-cycle pulse after the last write
//   rom_rd_en_o        ROM read enable
//   rom_rd_addr_o      ROM read address {bank, ctx}
//   rom_rd_dat_i       ROM data one cycle after the read: [15:8] m, [7:0] n
//   ctx_wr_en_o        context RAM write enable
//   ctx_wr_addr_o      context RAM write address
//   ctx_wr_dat_o       {pStateIdx[5:0], valMps}
module cabac_ctx_init_engine #(
  parameter int CTX_NUM   = 64,
  parameter int CTX_AW    = 6,
  parameter int NUM_BANKS = 3,
  parameter int BANK_AW   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [BANK_AW-1:0]        slice_type_i,
  input  logic [6:0]                qp_i,
`ifdef CABAC_INIT_FLAG_EN
  input  logic                      cabac_init_flag_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rom_rd_en_o,
  output logic [BANK_AW+CTX_AW-1:0] rom_rd_addr_o,
  input  logic [15:0]               rom_rd_dat_i,
  output logic                      ctx_wr_en_o,
  output logic [CTX_AW-1:0]         ctx_wr_addr_o,
  output logic [6:0]                ctx_wr_dat_o
);

  localparam logic [CTX_AW-1:0] CTX_LAST = CTX_AW'(CTX_NUM - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CTX_AW-1:0]     ctx_p0;
  logic                  drain_q;
  logic [BANK_AW-1:0]    bank_q;
  logic [5:0]            qpc_q;
  logic [BANK_AW-1:0]    bank_sel;
  logic                  vld_p1;
  logic [CTX_AW-1:0]     addr_p1;

  // Saturate the pre-state value into the legal range [1, 126].
  function automatic logic signed [15:0] clip_pre(input logic signed [15:0] v);
    if (v < 16'sd1)
      return 16'sd1;
    else if (v > 16'sd126)
      return 16'sd126;
    return v;
  endfunction

  // HEVC context init: pre = clip(((m * qpc) >>> 4) + n), then split into
  // MPS and state index. m*qpc fits in 14 signed bits since |m| <= 128 and
  // qpc <= 51.
  function automatic logic [6:0] init_state(input logic [15:0] word,
                                            input logic [5:0]  qpc);
    logic signed [13:0] m_ext;
    logic signed [13:0] q_ext;
    logic signed [13:0] prod;
    logic signed [13:0] sh;
    logic signed [15:0] sum;
    logic signed [15:0] pre;
    logic signed [15:0] ps;
    logic               mps;
    m_ext = {{6{word[15]}}, word[15:8]};
    q_ext = {8'd0, qpc};
    prod  = m_ext * q_ext;
    sh    = prod >>> 4;
    sum   = {{2{sh[13]}}, sh} + {8'd0, word[7:0]};
    pre   = clip_pre(sum);
    mps   = (pre > 16'sd63);
    ps    = mps ? (pre - 16'sd64) : (16'sd63 - pre);
    return {ps[5:0], mps};
  endfunction

  // Bank selection: out-of-range slice types fall back to bank 0 before
  // any optional B/P swap.
  always_comb begin
    bank_sel = slice_type_i;
    if (32'(slice_type_i) >= NUM_BANKS)
      bank_sel = '0;
`ifdef CABAC_INIT_FLAG_EN
    if (cabac_init_flag_i) begin
      if (bank_sel == BANK_AW'(0))
        bank_sel = BANK_AW'(1);
      else if (bank_sel == BANK_AW'(1))
        bank_sel = BANK_AW'(0);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    rom_rd_en_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i)
          state_d = READ;
      end
      READ: begin
        rom_rd_en_o = 1'b1;
        if (ctx_p0 == CTX_LAST)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q)
          state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_rd_addr_o = rom_rd_en_o ? {bank_q, ctx_p0} : '0;

  // Control path: FSM, read counter, pipeline valids and write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ctx_p0        <= '0;
      drain_q       <= 1'b0;
      vld_p1        <= 1'b0;
      ctx_wr_en_o   <= 1'b0;
      ctx_wr_addr_o <= '0;
      ctx_wr_dat_o  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == READ)
        ctx_p0 <= (ctx_p0 == CTX_LAST) ? '0 : ctx_p0 + CTX_AW'(1);
      else
        ctx_p0 <= '0;
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;

      // S0 -> S1: read issued; the ROM's own output register holds the data
      vld_p1 <= rom_rd_en_o;

      // S1 -> S2: arithmetic on ROM data, registered onto the write port
      ctx_wr_en_o   <= vld_p1;
      ctx_wr_addr_o <= vld_p1 ? addr_p1 : '0;
      ctx_wr_dat_o  <= vld_p1 ? init_state(rom_rd_dat_i, qpc_q) : '0;
    end
  end

  // Data path registers: parameters latched on accepted start, address
  // delayed alongside the ROM latency.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_i) begin
      bank_q <= bank_sel;
      qpc_q  <= (qp_i > 7'd51) ? 6'd51 : qp_i[5:0];
    end
    addr_p1 <= ctx_p0;
  end

endmodule

// File: tb/tb_cabac_ctx_init_engine.sv
// Testbench for cabac_ctx_init_engine: random ROM contents and slice
// parameters, cycle-by-cycle comparison against a behavioural model of the
// init sequence, plus directed arithmetic and control corner cases.
module tb_cabac_ctx_init_engine;

  localparam int CTX_NUM   = 64;
  localparam int CTX_AW    = 6;
  localparam int NUM_BANKS = 3;
  localparam int BANK_AW   = 2;
  localparam int ROM_DEPTH = 1 << (BANK_AW + CTX_AW);

  logic                      clk;
  logic                      rst;
  logic                      start_i;
  logic [BANK_AW-1:0]        slice_type_i;
  logic [6:0]                qp_i;
  logic                      cabac_init_flag_i;
  logic                      busy_o;
  logic                      done_o;
  logic                      rom_rd_en_o;
  logic [BANK_AW+CTX_AW-1:0] rom_rd_addr_o;
  logic [15:0]               rom_rd_dat_i;
  logic                      ctx_wr_en_o;
  logic [CTX_AW-1:0]         ctx_wr_addr_o;
  logic [6:0]                ctx_wr_dat_o;

  logic [15:0] rom [0:ROM_DEPTH-1];
  logic [15:0] rom_q;
  logic [6:0]  got_dat [0:CTX_NUM-1];
  int          checks;
  int          errors;

  cabac_ctx_init_engine #(
    .CTX_NUM  (CTX_NUM),
    .CTX_AW   (CTX_AW),
    .NUM_BANKS(NUM_BANKS),
    .BANK_AW  (BANK_AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .slice_type_i     (slice_type_i),
    .qp_i             (qp_i),
`ifdef CABAC_INIT_FLAG_EN
    .cabac_init_flag_i(cabac_init_flag_i),
`endif
    .busy_o           (busy_o),
    .done_o           (done_o),
    .rom_rd_en_o      (rom_rd_en_o),
    .rom_rd_addr_o    (rom_rd_addr_o),
    .rom_rd_dat_i     (rom_rd_dat_i),
    .ctx_wr_en_o      (ctx_wr_en_o),
    .ctx_wr_addr_o    (ctx_wr_addr_o),
    .ctx_wr_dat_o     (ctx_wr_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one cycle read latency.
  always @(posedge clk)
    if (rom_rd_en_o)
      rom_q <= rom[rom_rd_addr_o];
  assign rom_rd_dat_i = rom_q;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_bank(input int st, input bit flag);
    int b;
    b = (st >= NUM_BANKS) ? 0 : st;
`ifdef CABAC_INIT_FLAG_EN
    if (flag && b < 2)
      b = 1 - b;
`endif
    return b;
  endfunction

  function automatic logic [6:0] ref_state(input logic [15:0] w, input int qp);
    int qpc;
    int m;
    int n;
    int pre;
    int ps;
    bit mps;
    qpc = (qp > 51) ? 51 : qp;
    m   = $signed(w[15:8]);
    n   = w[7:0];
    pre = ((m * qpc) >>> 4) + n;
    if (pre < 1)   pre = 1;
    if (pre > 126) pre = 126;
    mps = (pre > 63);
    ps  = mps ? pre - 64 : 63 - pre;
    return {ps[5:0], mps};
  endfunction

  // One init sequence. Cycle 0 is the start cycle. repulse_c / rst_c select
  // a cycle for a stray start pulse or a reset (0 = none).
  task automatic run_seq(input int st, input int qp, input bit flag,
                         input int repulse_c, input int rst_c);
    int bank;
    bit live;
    bit rd;
    bit wr;
    int exp_addr;
    bank = ref_bank(st, flag);
    for (int i = 0; i < CTX_NUM; i++) got_dat[i] = '0;
    @(negedge clk);
    slice_type_i      = st[BANK_AW-1:0];
    qp_i              = qp[6:0];
    cabac_init_flag_i = flag;
    start_i           = 1'b1;
    for (int c = 1; c <= CTX_NUM + 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == repulse_c) begin
        start_i           = 1'b1;
        slice_type_i      = ~slice_type_i;
        qp_i              = qp_i ^ 7'h2a;
        cabac_init_flag_i = ~flag;
      end
      rst  = (c == rst_c);
      live = (rst_c == 0) || (c <= rst_c);
      rd   = live && c >= 1 && c <= CTX_NUM;
      wr   = live && c >= 3 && c <= CTX_NUM + 2;
      check_eq("busy", busy_o, live && c <= CTX_NUM + 3);
      check_eq("done", done_o, live && c == CTX_NUM + 3);
      check_eq("rd_en", rom_rd_en_o, rd);
      check_eq("rd_addr", rom_rd_addr_o, rd ? (bank << CTX_AW) + c - 1 : 0);
      check_eq("wr_en", ctx_wr_en_o, wr);
      check_eq("wr_addr", ctx_wr_addr_o, wr ? c - 3 : 0);
      exp_addr = (bank << CTX_AW) + c - 3;
      check_eq("wr_dat", ctx_wr_dat_o, wr ? ref_state(rom[exp_addr], qp) : 7'd0);
      if (ctx_wr_en_o)
        got_dat[ctx_wr_addr_o] = ctx_wr_dat_o;
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    start_i           = 1'b0;
    slice_type_i      = '0;
    qp_i              = '0;
    cabac_init_flag_i = 1'b0;
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h0040;
    rom[1] = 16'hf168;
    rom[2] = 16'h80ff;
    rom[3] = 16'h7fff;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_rd_en", rom_rd_en_o, 0);
    check_eq("rst_rd_addr", rom_rd_addr_o, 0);
    check_eq("rst_wr_en", ctx_wr_en_o, 0);
    check_eq("rst_wr_addr", ctx_wr_addr_o, 0);
    check_eq("rst_wr_dat", ctx_wr_dat_o, 0);
    rst = 1'b0;

    run_seq(0, 32, 1'b0, 0, 0);
    check_eq("tp_0040_q32", got_dat[0], {6'd0, 1'b1});
    check_eq("tp_f168_q32", got_dat[1], {6'd10, 1'b1});

    run_seq(0, 0, 1'b0, 0, 0);
    check_eq("tp_f168_q0", got_dat[1], {6'd40, 1'b1});

    run_seq(0, 60, 1'b0, 0, 0);
    check_eq("tp_f168_q60", got_dat[1], {6'd7, 1'b0});
    check_eq("tp_clip_lo", got_dat[2], {6'd62, 1'b0});
    check_eq("tp_clip_hi", got_dat[3], {6'd62, 1'b1});

    run_seq(1, 20, 1'b0, 10, 0);   // stray start mid-sequence
    run_seq(2, 40, 1'b0, 0, 20);   // reset mid-sequence
    run_seq(0, 30, 1'b0, 0, 0);    // restart after abort
    run_seq(3, 45, 1'b0, 0, 0);    // out-of-range slice type

`ifdef CABAC_INIT_FLAG_EN
    run_seq(1, 25, 1'b1, 0, 0);
    run_seq(1, 25, 1'b0, 0, 0);
    run_seq(2, 25, 1'b1, 0, 0);
    run_seq(0, 25, 1'b1, 0, 0);
`endif

    for (int r = 0; r < 6; r++)
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
              1'($urandom_range(0, 1)), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
